// File: rtl/framebuffer_mig_scheduler.sv
// Framebuffer scheduler for a MIG user interface.
// Streams scan-out reads from the displayed buffer, interleaves queued pixel
// writes, and rotates the displayed buffer on frame boundaries when a flip is
// requested. Read issue is throttled by the downstream FIFO fill plus reads
// still in flight, so the display FIFO can never be overrun.
module framebuffer_mig_scheduler #(
    parameter int NUM_BUFFERS  = 2,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int PIX_PER_BEAT = 4,
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int WQ_DEPTH     = 4,
    parameter int LOW_FILL     = 100,
    parameter int HIGH_FILL    = 200,
    parameter int COUNT_W      = 9
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic                             flip_req,
    output logic                             flip_done,
    input  logic [COUNT_W-1:0]               fill_level,
    input  logic                             rd_data_valid,
    input  logic                             app_rdy,
    input  logic                             app_wdf_rdy,
    output logic                             app_en,
    output logic                             app_wdf_wren,
    output logic                             app_wdf_end,
    output logic [2:0]                       app_cmd,
    output logic [ADDR_W-1:0]                app_addr,
    output logic [DATA_W-1:0]                app_wdf_data,
    output logic [$clog2(NUM_BUFFERS)-1:0]   active_buffer,
    output logic                             flip_dropped,
    output logic [15:0]                      write_count
);

    localparam int COL_W = $clog2(H_ACTIVE);
    localparam int ROW_W = $clog2(V_ACTIVE);
    localparam int BUF_W = $clog2(NUM_BUFFERS);
    localparam int RA_W  = BUF_W + ROW_W + COL_W;
    localparam int QA_W  = $clog2(WQ_DEPTH);

    localparam logic [COL_W-1:0]   COL_STEP   = COL_W'(PIX_PER_BEAT);
    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(H_ACTIVE - PIX_PER_BEAT);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(V_ACTIVE - 1);
    localparam logic [BUF_W-1:0]   LAST_BUF   = BUF_W'(NUM_BUFFERS - 1);
    localparam logic [COUNT_W:0]   LOW_LIMIT  = (COUNT_W+1)'(LOW_FILL);
    localparam logic [COUNT_W:0]   HIGH_LIMIT = (COUNT_W+1)'(HIGH_FILL);

    typedef enum logic [1:0] {
        ISSUE_IDLE,
        ISSUE_READ,
        ISSUE_WRITE
    } issue_t;

    issue_t              issue;

    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic [ADDR_W-1:0]   read_addr;
    logic                rd_issue;
    logic                wr_issue;
    logic                frame_wrap;

    logic [COUNT_W-1:0]  outstanding;
    logic [COUNT_W:0]    eff_fill;

    logic [ADDR_W-1:0]   q_addr [WQ_DEPTH];
    logic [DATA_W-1:0]   q_data [WQ_DEPTH];
    logic [QA_W:0]       wr_ptr;
    logic [QA_W:0]       rd_ptr;
    logic                q_empty;
    logic                q_full;
    logic                push;

    logic                flip_prev;
    logic                flip_pending;
    logic                flip_edge;
    logic [BUF_W-1:0]    next_buffer;

    // Queue status uses an extra pointer bit to tell full from empty.
    assign q_empty  = (wr_ptr == rd_ptr);
    assign q_full   = (wr_ptr[QA_W] != rd_ptr[QA_W]) &&
                      (wr_ptr[QA_W-1:0] == rd_ptr[QA_W-1:0]);
    assign wr_ready = ~q_full;
    assign push     = wr_valid & wr_ready;

    assign read_addr  = {{(ADDR_W-RA_W){1'b0}}, active_buffer, row, col};
    assign eff_fill   = {1'b0, fill_level} + {1'b0, outstanding};
    assign rd_issue   = (issue == ISSUE_READ);
    assign wr_issue   = (issue == ISSUE_WRITE);
    assign frame_wrap = rd_issue && (col == LAST_COL) && (row == LAST_ROW);
    assign flip_edge  = flip_req & ~flip_prev;
    assign next_buffer = (active_buffer == LAST_BUF) ? '0 : active_buffer + BUF_W'(1);

    // Pick this cycle's command: urgent read, then write, then opportunistic read.
    always_comb begin
        issue = ISSUE_IDLE;
        if (!rst && app_rdy) begin
            if (eff_fill <= LOW_LIMIT) begin
                issue = ISSUE_READ;
            end else if (!q_empty && app_wdf_rdy) begin
                issue = ISSUE_WRITE;
            end else if (eff_fill < HIGH_LIMIT) begin
                issue = ISSUE_READ;
            end
        end
    end

    // Drive the MIG command and write-data channels from the chosen command.
    always_comb begin
        app_en       = (issue != ISSUE_IDLE);
        app_cmd      = wr_issue ? 3'b000 : 3'b001;
        app_addr     = wr_issue ? q_addr[rd_ptr[QA_W-1:0]] : read_addr;
        app_wdf_data = q_data[rd_ptr[QA_W-1:0]];
        app_wdf_wren = wr_issue;
        app_wdf_end  = 1'b1;
    end

    // Scan-out pointer walks columns then rows, wrapping at the end of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (rd_issue) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_STEP;
            end
        end
    end

    // Track reads issued but not yet returned; a stray return never underflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else if (rd_issue && !rd_data_valid) begin
            outstanding <= outstanding + COUNT_W'(1);
        end else if (!rd_issue && rd_data_valid && outstanding != '0) begin
            outstanding <= outstanding - COUNT_W'(1);
        end
    end

    // Write-request storage; contents need no reset since pointers guard them.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr[QA_W-1:0]] <= wr_addr;
            q_data[wr_ptr[QA_W-1:0]] <= wr_data;
        end
    end

    // Queue pointers and the count of writes handed to the controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            write_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (QA_W+1)'(1);
            end
            if (wr_issue) begin
                rd_ptr      <= rd_ptr + (QA_W+1)'(1);
                write_count <= write_count + 16'd1;
            end
        end
    end

    // Flip handling: one pending request at a time, applied on frame wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            flip_prev     <= 1'b0;
            flip_pending  <= 1'b0;
            flip_dropped  <= 1'b0;
            flip_done     <= 1'b0;
            active_buffer <= '0;
        end else begin
            flip_prev <= flip_req;
            flip_done <= 1'b0;
            if (frame_wrap && flip_pending) begin
                active_buffer <= next_buffer;
                flip_done     <= 1'b1;
                flip_pending  <= flip_edge;
            end else if (flip_edge) begin
                if (flip_pending) begin
                    flip_dropped <= 1'b1;
                end else begin
                    flip_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_mig_scheduler.sv
// Self-checking bench for framebuffer_mig_scheduler. A behavioural model built
// from read counts, integer arithmetic and queues predicts every command.
module tb_framebuffer_mig_scheduler;

    localparam int AW    = 28;
    localparam int DW    = 128;
    localparam int CW    = 9;
    localparam int PPB   = 4;
    localparam int H0    = 640;
    localparam int V0    = 4;
    localparam int NB0   = 2;
    localparam int COLW0 = $clog2(H0);
    localparam int ROWW0 = $clog2(V0);
    localparam int BPL0  = H0 / PPB;
    localparam int FRAME0 = BPL0 * V0;
    localparam int H1    = 16;
    localparam int V1    = 4;
    localparam int NB1   = 3;
    localparam int COLW1 = $clog2(H1);
    localparam int ROWW1 = $clog2(V1);

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          flip_req;
    logic          flip_done;
    logic [CW-1:0] fill_level;
    logic          rd_data_valid;
    logic          app_rdy;
    logic          app_wdf_rdy;
    logic          app_en;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic [DW-1:0] app_wdf_data;
    logic [0:0]    active_buffer;
    logic          flip_dropped;
    logic [15:0]   write_count;

    logic          rst1;
    logic          flip_req1;
    logic          flip_done1;
    logic          wr_ready1;
    logic          app_en1;
    logic          app_wdf_wren1;
    logic          app_wdf_end1;
    logic [2:0]    app_cmd1;
    logic [AW-1:0] app_addr1;
    logic [DW-1:0] app_wdf_data1;
    logic [1:0]    active_buffer1;
    logic          flip_dropped1;
    logic [15:0]   write_count1;

    int tests_run;
    int tests_failed;

    // Model state
    int            m_reads;
    int            m_out;
    int            m_buf;
    int            m_wcount;
    bit            m_pending;
    bit            m_dropped;
    bit            m_done;
    bit            m_prev;
    logic [AW-1:0] m_qa[$];
    logic [DW-1:0] m_qd[$];

    // Per-cycle predictions
    bit            e_rd;
    bit            e_wr;
    bit            e_wr_ready;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    framebuffer_mig_scheduler #(
        .NUM_BUFFERS(NB0), .H_ACTIVE(H0), .V_ACTIVE(V0), .PIX_PER_BEAT(PPB),
        .ADDR_W(AW), .DATA_W(DW), .WQ_DEPTH(4), .LOW_FILL(100),
        .HIGH_FILL(200), .COUNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .flip_req(flip_req),
        .flip_done(flip_done), .fill_level(fill_level),
        .rd_data_valid(rd_data_valid), .app_rdy(app_rdy),
        .app_wdf_rdy(app_wdf_rdy), .app_en(app_en), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_wdf_data(app_wdf_data), .active_buffer(active_buffer),
        .flip_dropped(flip_dropped), .write_count(write_count)
    );

    framebuffer_mig_scheduler #(
        .NUM_BUFFERS(NB1), .H_ACTIVE(H1), .V_ACTIVE(V1), .PIX_PER_BEAT(PPB),
        .ADDR_W(AW), .DATA_W(DW), .WQ_DEPTH(4), .LOW_FILL(100),
        .HIGH_FILL(200), .COUNT_W(CW)
    ) dut3 (
        .clk(clk), .rst(rst1), .wr_valid(1'b0), .wr_ready(wr_ready1),
        .wr_addr({AW{1'b0}}), .wr_data({DW{1'b0}}), .flip_req(flip_req1),
        .flip_done(flip_done1), .fill_level({CW{1'b0}}),
        .rd_data_valid(1'b1), .app_rdy(1'b1), .app_wdf_rdy(1'b0),
        .app_en(app_en1), .app_wdf_wren(app_wdf_wren1),
        .app_wdf_end(app_wdf_end1), .app_cmd(app_cmd1), .app_addr(app_addr1),
        .app_wdf_data(app_wdf_data1), .active_buffer(active_buffer1),
        .flip_dropped(flip_dropped1), .write_count(write_count1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Predict this cycle's command from the model state and current inputs.
    function automatic void model_predict();
        int eff;
        int n;
        e_rd   = 1'b0;
        e_wr   = 1'b0;
        e_addr = '0;
        e_data = '0;
        eff = int'(fill_level) + m_out;
        if (!rst && app_rdy) begin
            if (eff <= 100) e_rd = 1'b1;
            else if (m_qa.size() > 0 && app_wdf_rdy) e_wr = 1'b1;
            else if (eff < 200) e_rd = 1'b1;
        end
        if (e_rd) begin
            n = m_reads % FRAME0;
            e_addr = AW'(m_buf * (1 << (COLW0 + ROWW0)) + (n / BPL0) * (1 << COLW0) + (n % BPL0) * PPB);
        end
        if (e_wr) begin
            e_addr = m_qa[0];
            e_data = m_qd[0];
        end
        e_wr_ready = (m_qa.size() < 4);
    endfunction

    // Advance the model by one clock using the predicted command.
    task automatic model_commit();
        bit edge_seen;
        bit wrap;
        int pre_size;
        if (rst) begin
            m_reads = 0; m_out = 0; m_buf = 0; m_wcount = 0;
            m_pending = 0; m_dropped = 0; m_done = 0; m_prev = 0;
            m_qa.delete(); m_qd.delete();
            return;
        end
        edge_seen = flip_req && !m_prev;
        m_prev = flip_req;
        wrap = e_rd && ((m_reads % FRAME0) == FRAME0 - 1);
        pre_size = m_qa.size();
        if (e_rd && !rd_data_valid) m_out++;
        else if (!e_rd && rd_data_valid && m_out > 0) m_out--;
        if (e_rd) m_reads++;
        if (e_wr) begin
            void'(m_qa.pop_front());
            void'(m_qd.pop_front());
            m_wcount = (m_wcount + 1) % 65536;
        end
        if (wr_valid && pre_size < 4) begin
            m_qa.push_back(wr_addr);
            m_qd.push_back(wr_data);
        end
        m_done = 1'b0;
        if (wrap && m_pending) begin
            m_buf = (m_buf + 1) % NB0;
            m_done = 1'b1;
            m_pending = edge_seen;
        end else if (edge_seen) begin
            if (m_pending) m_dropped = 1'b1;
            else m_pending = 1'b1;
        end
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        model_predict();
    endtask

    task automatic cyc_end();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [CW-1:0] fill, input logic rdy,
                                 input logic wdf, input logic rdv);
        fill_level    = fill;
        app_rdy       = rdy;
        app_wdf_rdy   = wdf;
        rd_data_valid = rdv;
        wr_valid      = 1'b0;
        flip_req      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc_begin();
        cyc_end();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus(9'd0, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        cyc_begin();
        tests_run++;
        if (app_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_cmd: app_en=%0b expected 0", app_en);
        end
        cyc_end();
        rst = 1'b0;
        app_rdy = 1'b0;
        cyc_begin();
        tests_run++;
        if (wr_ready !== 1'b1 || active_buffer !== 1'b0 || flip_dropped !== 1'b0 ||
            flip_done !== 1'b0 || write_count !== 16'd0 || app_wdf_end !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: wr_ready=%0b buf=%0d dropped=%0b done=%0b wcount=%0d end=%0b expected 1 0 0 0 0 1",
                     wr_ready, active_buffer, flip_dropped, flip_done, write_count, app_wdf_end);
        end
        cyc_end();
    endtask

    task automatic test_read_stream();
        do_reset();
        applyStimulus(9'd0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 210; c++) begin
            cyc_begin();
            tests_run++;
            if (app_en !== (e_rd | e_wr) ||
                (e_rd && (app_cmd !== 3'b001 || app_addr !== e_addr || app_wdf_wren !== 1'b0))) begin
                tests_failed++;
                $display("[TB] FAIL read_stream c=%0d: en=%0b cmd=%0d addr=%0h expected en=%0b cmd=1 addr=%0h",
                         c, app_en, app_cmd, app_addr, e_rd | e_wr, e_addr);
            end
            if (c == 159) begin
                tests_run++;
                if (app_en !== 1'b1 || app_addr !== 28'd636) begin
                    tests_failed++;
                    $display("[TB] FAIL last_column: en=%0b addr=%0d expected 1 636", app_en, app_addr);
                end
            end
            if (c == 160) begin
                tests_run++;
                if (app_en !== 1'b1 || app_addr !== 28'd1024) begin
                    tests_failed++;
                    $display("[TB] FAIL row_one: en=%0b addr=%0d expected 1 1024", app_en, app_addr);
                end
            end
            if (c == 205) begin
                tests_run++;
                if (app_en !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL credit_limit: en=%0b expected 0", app_en);
                end
            end
            cyc_end();
        end
    endtask

    task automatic test_writes_first();
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        do_reset();
        applyStimulus(9'd150, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            a[i] = AW'($urandom);
            d[i] = {$urandom, $urandom, $urandom, $urandom};
            wr_valid = 1'b1;
            wr_addr  = a[i];
            wr_data  = d[i];
            cyc_begin();
            cyc_end();
        end
        wr_valid = 1'b0;
        app_rdy  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc_begin();
            tests_run++;
            if (app_en !== (e_rd | e_wr) || app_wdf_wren !== e_wr || app_addr !== e_addr) begin
                tests_failed++;
                $display("[TB] FAIL writes_model c=%0d: en=%0b wren=%0b addr=%0h expected %0b %0b %0h",
                         c, app_en, app_wdf_wren, app_addr, e_rd | e_wr, e_wr, e_addr);
            end
            tests_run++;
            if (c < 2) begin
                if (app_en !== 1'b1 || app_cmd !== 3'b000 || app_wdf_wren !== 1'b1 ||
                    app_addr !== a[c] || app_wdf_data !== d[c]) begin
                    tests_failed++;
                    $display("[TB] FAIL write_first c=%0d: cmd=%0d wren=%0b addr=%0h expected cmd=0 wren=1 addr=%0h",
                             c, app_cmd, app_wdf_wren, app_addr, a[c]);
                end
            end else begin
                if (app_en !== 1'b1 || app_cmd !== 3'b001 || write_count !== 16'd2) begin
                    tests_failed++;
                    $display("[TB] FAIL read_after_writes: en=%0b cmd=%0d wcount=%0d expected 1 1 2",
                             app_en, app_cmd, write_count);
                end
            end
            cyc_end();
        end
    endtask

    task automatic test_queue_full_reset();
        do_reset();
        applyStimulus(9'd250, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            wr_valid = 1'b1;
            wr_addr  = AW'($urandom);
            wr_data  = {$urandom, $urandom, $urandom, $urandom};
            cyc_begin();
            tests_run++;
            if (wr_ready !== (c < 4) || wr_ready !== e_wr_ready || app_en !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL queue_fill c=%0d: wr_ready=%0b en=%0b expected wr_ready=%0b en=0",
                         c, wr_ready, app_en, c < 4);
            end
            cyc_end();
        end
        wr_valid    = 1'b0;
        app_wdf_rdy = 1'b1;
        rst         = 1'b1;
        cyc_begin();
        tests_run++;
        if (app_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_cycle_cmd: en=%0b expected 0", app_en);
        end
        cyc_end();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cyc_begin();
            tests_run++;
            if (app_wdf_wren !== 1'b0 || wr_ready !== 1'b1 || write_count !== 16'd0) begin
                tests_failed++;
                $display("[TB] FAIL queue_cleared c=%0d: wren=%0b wr_ready=%0b wcount=%0d expected 0 1 0",
                         c, app_wdf_wren, wr_ready, write_count);
            end
            cyc_end();
        end
    endtask

    task automatic test_credit_saturation();
        do_reset();
        applyStimulus(9'd0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            cyc_begin();
            cyc_end();
        end
        applyStimulus(9'd100, 1'b1, 1'b0, 1'b0);
        cyc_begin();
        tests_run++;
        if (app_en !== 1'b1 || app_cmd !== 3'b001 || e_rd !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL credit_no_underflow: en=%0b cmd=%0d expected 1 1", app_en, app_cmd);
        end
        cyc_end();
        applyStimulus(9'd198, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            cyc_begin();
            tests_run++;
            if (app_en !== 1'b1 || app_en !== e_rd) begin
                tests_failed++;
                $display("[TB] FAIL credit_same_cycle c=%0d: en=%0b expected 1", c, app_en);
            end
            cyc_end();
        end
        rd_data_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cyc_begin();
            tests_run++;
            if (app_en !== (c == 0)) begin
                tests_failed++;
                $display("[TB] FAIL credit_high c=%0d: en=%0b expected %0b", c, app_en, c == 0);
            end
            cyc_end();
        end
    endtask

    task automatic test_flip();
        do_reset();
        applyStimulus(9'd0, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < FRAME0 + 10; c++) begin
            flip_req = (c == 100 || c == 101 || c == 300);
            cyc_begin();
            tests_run++;
            if (app_en !== e_rd || (e_rd && app_addr !== e_addr) || flip_done !== m_done ||
                active_buffer !== 1'(m_buf) || flip_dropped !== m_dropped) begin
                tests_failed++;
                $display("[TB] FAIL flip_model c=%0d: en=%0b addr=%0h done=%0b buf=%0d drop=%0b expected %0b %0h %0b %0d %0b",
                         c, app_en, app_addr, flip_done, active_buffer, flip_dropped,
                         e_rd, e_addr, m_done, m_buf, m_dropped);
            end
            if (c == 400) begin
                tests_run++;
                if (flip_dropped !== 1'b1 || active_buffer !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL flip_dropped: drop=%0b buf=%0d expected 1 0", flip_dropped, active_buffer);
                end
            end
            if (c == FRAME0 - 1) begin
                tests_run++;
                if (app_addr !== 28'd3708 || flip_done !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL frame_end: addr=%0d done=%0b expected 3708 0", app_addr, flip_done);
                end
            end
            if (c == FRAME0) begin
                tests_run++;
                if (flip_done !== 1'b1 || active_buffer !== 1'b1 || app_en !== 1'b1 || app_addr !== 28'h1000) begin
                    tests_failed++;
                    $display("[TB] FAIL flip_applied: done=%0b buf=%0d addr=%0h expected 1 1 1000",
                             flip_done, active_buffer, app_addr);
                end
            end
            if (c == FRAME0 + 1) begin
                tests_run++;
                if (flip_done !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL flip_pulse_width: done=%0b expected 0", flip_done);
                end
            end
            cyc_end();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            fill_level    = CW'($urandom_range(0, 260));
            app_rdy       = ($urandom_range(0, 3) != 0);
            app_wdf_rdy   = $urandom_range(0, 1);
            rd_data_valid = ($urandom_range(0, 2) == 0);
            wr_valid      = $urandom_range(0, 1);
            wr_addr       = AW'($urandom);
            wr_data       = {$urandom, $urandom, $urandom, $urandom};
            flip_req      = ($urandom_range(0, 15) == 0);
            cyc_begin();
            tests_run++;
            if (app_en !== (e_rd | e_wr) || app_wdf_wren !== e_wr ||
                ((e_rd | e_wr) && (app_addr !== e_addr || app_cmd !== (e_wr ? 3'b000 : 3'b001))) ||
                (e_wr && app_wdf_data !== e_data)) begin
                tests_failed++;
                $display("[TB] FAIL random_cmd c=%0d: en=%0b cmd=%0d wren=%0b addr=%0h expected en=%0b wr=%0b addr=%0h",
                         c, app_en, app_cmd, app_wdf_wren, app_addr, e_rd | e_wr, e_wr, e_addr);
            end
            tests_run++;
            if (wr_ready !== e_wr_ready || write_count !== 16'(m_wcount) ||
                flip_dropped !== m_dropped || active_buffer !== 1'(m_buf)) begin
                tests_failed++;
                $display("[TB] FAIL random_status c=%0d: wr_ready=%0b wcount=%0d drop=%0b buf=%0d expected %0b %0d %0b %0d",
                         c, wr_ready, write_count, flip_dropped, active_buffer,
                         e_wr_ready, m_wcount, m_dropped, m_buf);
            end
            cyc_end();
        end
        wr_valid = 1'b0;
        flip_req = 1'b0;
    endtask

    task automatic test_three_buffers();
        int expb [3];
        bit seen;
        expb[0] = 1; expb[1] = 2; expb[2] = 0;
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            flip_req1 = 1'b1;
            @(posedge clk); #1;
            flip_req1 = 1'b0;
            seen = 1'b0;
            for (int w = 0; w < 40 && !seen; w++) begin
                @(negedge clk);
                if (flip_done1 === 1'b1) seen = 1'b1;
            end
            tests_run++;
            if (!seen) begin
                tests_failed++;
                $display("[TB] FAIL three_buf_timeout flip=%0d: flip_done never seen, expected pulse", i);
            end else if (active_buffer1 !== 2'(expb[i]) || app_en1 !== 1'b1 ||
                         app_addr1 !== AW'(expb[i] << (COLW1 + ROWW1))) begin
                tests_failed++;
                $display("[TB] FAIL three_buf flip=%0d: buf=%0d addr=%0h expected buf=%0d addr=%0h",
                         i, active_buffer1, app_addr1, expb[i], AW'(expb[i] << (COLW1 + ROWW1)));
            end
            @(negedge clk);
            tests_run++;
            if (flip_done1 !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL three_buf_pulse flip=%0d: done=%0b expected 0", i, flip_done1);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst1         = 1'b1;
        flip_req1    = 1'b0;
        rst          = 1'b1;
        wr_addr      = '0;
        wr_data      = '0;
        applyStimulus(9'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        test_reset();
        test_read_stream();
        test_writes_first();
        test_queue_full_reset();
        test_credit_saturation();
        test_flip();
        test_random();
        test_three_buffers();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
